// File: rtl/pipe_field.sv
// pipe_field: NUM_PIPES scrolling pipe pairs with frame-synchronous motion, LFSR gap
// placement, difficulty levels and pass detection. Define PIPE_CAP_EN to build the cap overlay.
module pipe_field #(
  parameter int          NUM_PIPES      = 4,
  parameter int          PIPE_WIDTH     = 40,
  parameter int          PIPE_SPACING   = 220,
  parameter int          SCREEN_WIDTH   = 640,
  parameter int          VISIBLE_HEIGHT = 480,
  parameter int          RESPAWN_PX     = 720,
  parameter int          BIRD_X         = 160,
  parameter int          GAP_MIN_TOP    = 60,
  parameter int          TOP_SPAN       = 256,
  parameter int          GAP_MAX_SIZE   = 150,
  parameter int          GAP_MIN_SIZE   = 100,
  parameter int          GAP_STEP       = 10,
  parameter int          LEVEL_PASSES   = 8,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       freeze,
  input  logic       frame_tick,
  input  logic [1:0] speed,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  output logic       pipe_pixel,
  output logic       pipe_cap,
  output logic       pass_pulse,
  output logic [3:0] level,
  output logic [1:0] state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FROZEN = 2'd2} state_t;
  localparam int CW = $clog2(LEVEL_PASSES + 1);

  state_t        st, st_nxt;
  logic [11:0]   px     [NUM_PIPES];
  logic [9:0]    top    [NUM_PIPES];
  logic [9:0]    size   [NUM_PIPES];
  logic [11:0]   px_nxt [NUM_PIPES];
  logic [15:0]   lfsr;
  logic [CW-1:0] pass_cnt;

  logic [11:0] step, resp_px;
  logic [2:0]  sel;
  logic        any_resp, any_cross, hit;
  logic [8:0]  r_raw, r_fold;
  logic [9:0]  top_nxt, size_nxt;
  int          sz;

  function automatic logic [11:0] init_px(int i);
    return 12'(RESPAWN_PX + i * PIPE_SPACING);
  endfunction

  function automatic logic [9:0] init_top(int i);
    return 10'(GAP_MIN_TOP + 60 * i);
  endfunction

  assign state = st;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    st_nxt = st;
    unique case (st)
      S_IDLE:   if (start)  st_nxt = S_RUN;
      S_RUN:    if (freeze) st_nxt = S_FROZEN;
      S_FROZEN: if (start)  st_nxt = S_IDLE;
      default:  st_nxt = S_IDLE;
    endcase
  end

  // Motion for one tick: move every pipe, respawn only the lowest-index exhausted one.
  always_comb begin
    step      = 12'(speed) + 12'd1;
    any_resp  = 1'b0;
    any_cross = 1'b0;
    sel       = '0;
    for (int i = NUM_PIPES - 1; i >= 0; i--)
      if (px[i] <= step) begin
        any_resp = 1'b1;
        sel      = 3'(i);
      end
    for (int i = 0; i < NUM_PIPES; i++) begin
      px_nxt[i] = (px[i] > step) ? px[i] - step : px[i];
      if (px[i] > step && px[i] > 12'(BIRD_X) && px_nxt[i] <= 12'(BIRD_X)) any_cross = 1'b1;
    end
    resp_px = 12'(RESPAWN_PX);
    for (int i = 0; i < NUM_PIPES; i++)
      if (3'(i) != sel && px_nxt[i] + 12'(PIPE_SPACING) > resp_px)
        resp_px = px_nxt[i] + 12'(PIPE_SPACING);
    for (int i = 0; i < NUM_PIPES; i++)
      if (any_resp && 3'(i) == sel) px_nxt[i] = resp_px;

    r_raw    = lfsr[8:0] ^ 9'(32'(sel) * 32'h0B5);
    r_fold   = ({1'b0, r_raw} >= 10'(TOP_SPAN)) ? 9'({1'b0, r_raw} - 10'(TOP_SPAN)) : r_raw;
    top_nxt  = 10'(GAP_MIN_TOP) + 10'(r_fold);
    sz       = GAP_MAX_SIZE - GAP_STEP * int'(level);
    if (sz < GAP_MIN_SIZE) sz = GAP_MIN_SIZE;
    size_nxt = 10'(sz);
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_PIPES; i++)
      if (12'(hCount) < px[i] && 12'(hCount) + 12'(PIPE_WIDTH) >= px[i] &&
          !(vCount >= top[i] && 11'(vCount) < 11'(top[i]) + 11'(size[i])))
        hit = 1'b1;
    if (hCount >= 10'(SCREEN_WIDTH) || vCount >= 10'(VISIBLE_HEIGHT)) hit = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st         <= S_IDLE;
      lfsr       <= LFSR_SEED;
      level      <= '0;
      pass_cnt   <= '0;
      pass_pulse <= 1'b0;
      pipe_pixel <= 1'b0;
      // NOTE: the per-pipe arrays are a handful of flops, not a RAM, so they take reset values.
      for (int i = 0; i < NUM_PIPES; i++) begin
        px[i]   <= init_px(i);
        top[i]  <= init_top(i);
        size[i] <= 10'(GAP_MAX_SIZE);
      end
    end else begin
      st         <= st_nxt;
      pass_pulse <= 1'b0;
      pipe_pixel <= hit;
      if (st == S_RUN) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      if (st == S_FROZEN && start) begin
        level    <= '0;
        pass_cnt <= '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
          px[i]   <= init_px(i);
          top[i]  <= init_top(i);
          size[i] <= 10'(GAP_MAX_SIZE);
        end
      end else if (st == S_RUN && frame_tick) begin
        for (int i = 0; i < NUM_PIPES; i++) begin
          px[i] <= px_nxt[i];
          if (any_resp && 3'(i) == sel) begin
            top[i]  <= top_nxt;
            size[i] <= size_nxt;
          end
        end
        if (any_cross) begin
          pass_pulse <= 1'b1;
          if (pass_cnt == CW'(LEVEL_PASSES - 1)) begin
            pass_cnt <= '0;
            if (level != 4'd15) level <= level + 4'd1;
          end else begin
            pass_cnt <= pass_cnt + CW'(1);
          end
        end
      end
    end
  end

`ifdef PIPE_CAP_EN
  logic cap_hit;

  // Caps are 12-row bands bordering the gap, 4 px wider than the pipe on each side.
  always_comb begin
    cap_hit = 1'b0;
    for (int i = 0; i < NUM_PIPES; i++)
      if (12'(hCount) < px[i] + 12'd4 && 12'(hCount) + 12'(PIPE_WIDTH + 4) >= px[i] &&
          ((11'(vCount) + 11'd12 >= 11'(top[i]) && vCount < top[i]) ||
           (11'(vCount) >= 11'(top[i]) + 11'(size[i]) &&
            11'(vCount) < 11'(top[i]) + 11'(size[i]) + 11'd12)))
        cap_hit = 1'b1;
    if (hCount >= 10'(SCREEN_WIDTH) || vCount >= 10'(VISIBLE_HEIGHT)) cap_hit = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pipe_cap <= 1'b0;
    else          pipe_cap <= cap_hit;
  end
`else
  assign pipe_cap = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_field.sv
// tb_pipe_field: randomized stimulus for pipe_field checked every cycle against a
// pipe-list reference model (positions, gaps, LFSR, pass count and level).
module tb_pipe_field;
  localparam int NP = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, freeze = 1'b0, frame_tick = 1'b0;
  logic [1:0] speed = 2'd0;
  logic [9:0] hCount = 10'd0, vCount = 10'd0;
  logic       pipe_pixel, pipe_cap, pass_pulse;
  logic [3:0] level;
  logic [1:0] state;

  always #5 clk = ~clk;

  pipe_field dut (
    .clk(clk), .reset_n(reset_n), .start(start), .freeze(freeze), .frame_tick(frame_tick),
    .speed(speed), .hCount(hCount), .vCount(vCount), .pipe_pixel(pipe_pixel),
    .pipe_cap(pipe_cap), .pass_pulse(pass_pulse), .level(level), .state(state)
  );

  int n_vec = 0, n_err = 0;
  int m_px[NP], m_top[NP], m_size[NP];
  int m_lfsr, m_level, m_cnt, m_state, m_pass, m_pix, m_cap;

  task automatic check(string tag, int got, int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reload();
    for (int i = 0; i < NP; i++) begin
      m_px[i]   = 720 + i * 220;
      m_top[i]  = 60 + 60 * i;
      m_size[i] = 150;
    end
    m_level = 0;
    m_cnt   = 0;
  endfunction

  function automatic void model_full_reset();
    model_reload();
    m_lfsr  = 16'hACE1;
    m_state = 0;
    m_pass  = 0;
    m_pix   = 0;
    m_cap   = 0;
  endfunction

  function automatic int clamp10(int x);
    return (x < 0) ? 0 : (x > 1023) ? 1023 : x;
  endfunction

  // One clock: predict from the pre-edge model and inputs, clock, then compare.
  task automatic cycle();
    int h, v, step, sel, rp, r, ns;
    int npx[NP];
    bit pix, cap, pass;
    h = int'(hCount); v = int'(vCount);
    pix = 0; cap = 0; pass = 0;
    if (h < 640 && v < 480)
      for (int i = 0; i < NP; i++) begin
        if (h < m_px[i] && h + 40 >= m_px[i] && !(v >= m_top[i] && v < m_top[i] + m_size[i]))
          pix = 1;
`ifdef PIPE_CAP_EN
        if (h < m_px[i] + 4 && h + 44 >= m_px[i] &&
            ((v >= m_top[i] - 12 && v < m_top[i]) ||
             (v >= m_top[i] + m_size[i] && v < m_top[i] + m_size[i] + 12)))
          cap = 1;
`endif
      end

    if (m_state == 1 && frame_tick) begin
      step = 1 + int'(speed);
      sel = -1;
      for (int i = 0; i < NP; i++) begin
        npx[i] = (m_px[i] > step) ? m_px[i] - step : m_px[i];
        if (sel < 0 && m_px[i] <= step) sel = i;
        if (m_px[i] > step && m_px[i] > 160 && npx[i] <= 160) pass = 1;
      end
      if (sel >= 0) begin
        rp = 720;
        for (int j = 0; j < NP; j++)
          if (j != sel && npx[j] + 220 > rp) rp = npx[j] + 220;
        npx[sel] = rp;
        r = ((m_lfsr & 511) ^ ((sel * 'hB5) & 511)) % 256;
        m_top[sel]  = 60 + r;
        m_size[sel] = (150 - 10 * m_level < 100) ? 100 : 150 - 10 * m_level;
      end
      for (int i = 0; i < NP; i++) m_px[i] = npx[i];
      if (pass) begin
        m_cnt++;
        if (m_cnt == 8) begin
          m_cnt = 0;
          if (m_level < 15) m_level++;
        end
      end
    end else if (m_state == 2 && start) begin
      model_reload();
    end

    if (m_state == 1) m_lfsr = (m_lfsr & 1) ? ((m_lfsr >> 1) ^ 'hB400) : (m_lfsr >> 1);
    ns = m_state;
    case (m_state)
      0: if (start)  ns = 1;
      1: if (freeze) ns = 2;
      default: if (start) ns = 0;
    endcase

    @(posedge clk);
    #1;
    if (!reset_n) model_full_reset();
    else begin
      m_pix = pix; m_cap = cap; m_pass = pass; m_state = ns;
    end
    check("pipe_pixel", pipe_pixel, m_pix);
    check("pipe_cap", pipe_cap, m_cap);
    check("pass_pulse", pass_pulse, m_pass);
    check("state", state, m_state);
    check("level", level, m_level);
  endtask

  // Probes are biased toward pipe columns and gap/cap boundary rows.
  task automatic set_probe();
    int p, v;
    p = $urandom_range(0, NP - 1);
    if ($urandom_range(0, 3) == 0) begin
      hCount = 10'($urandom);
      vCount = 10'($urandom);
    end else begin
      hCount = 10'(clamp10(m_px[p] + 1 - int'($urandom_range(0, 46))));
      case ($urandom_range(0, 5))
        0:       v = m_top[p] - 1;
        1:       v = m_top[p];
        2:       v = m_top[p] + m_size[p] - 1;
        3:       v = m_top[p] + m_size[p];
        4:       v = m_top[p] - int'($urandom_range(0, 14));
        default: v = m_top[p] + m_size[p] + int'($urandom_range(0, 14));
      endcase
      vCount = 10'(clamp10(v));
    end
  endtask

  task automatic drive(bit tk, bit st, bit fz, int spd);
    frame_tick = tk;
    start      = st;
    freeze     = fz;
    speed      = 2'(spd);
    set_probe();
    cycle();
  endtask

  initial begin
    int p;
    model_full_reset();
    repeat (3) drive(0, 0, 0, 0);
    reset_n = 1'b1;
    repeat (2) drive(0, 0, 0, 0);
    drive(0, 1, 0, 0);

    // Slow scroll: first move, pass of pipe 0 at tick 560, respawn at tick 720.
    for (int k = 0; k < 725; k++) begin
      drive(1, 0, 0, 0);
      drive(0, 0, 0, 0);
    end

    // Freeze holds positions; start returns to IDLE with reloaded pipes.
    drive(0, 0, 1, 0);
    repeat (5) drive(1, 0, 0, 2);
    drive(0, 1, 0, 0);
    repeat (3) drive(1, 0, 0, 1);
    drive(0, 1, 0, 0);

    // Long random run: enough passes to climb levels past the gap-size floor.
    for (int k = 0; k < 10000; k++)
      drive(bit'($urandom_range(0, 1)), $urandom_range(0, 49) == 0, 0, int'($urandom_range(0, 3)));

    // freeze and start together in RUN: freeze wins.
    drive(0, 1, 1, 0);
    drive(1, 0, 0, 3);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);

    // Mixed state-machine traffic.
    for (int k = 0; k < 2000; k++)
      drive(bit'($urandom_range(0, 1)), $urandom_range(0, 59) == 0,
            $urandom_range(0, 79) == 0, int'($urandom_range(0, 3)));

    // Async reset mid-cycle while the registered pixel is (likely) high.
    frame_tick = 0; start = 0; freeze = 0;
    p = -1;
    for (int i = 0; i < NP; i++) if (p < 0 && m_px[i] >= 1 && m_px[i] <= 640) p = i;
    if (p >= 0) begin
      hCount = 10'(m_px[p] - 1);
      vCount = 10'((m_top[p] > 0) ? m_top[p] - 1 : m_top[p] + m_size[p]);
    end
    cycle();
    #2 reset_n = 1'b0;
    #1;
    model_full_reset();
    check("async_rst_pixel", pipe_pixel, m_pix);
    check("async_rst_pass", pass_pulse, m_pass);
    check("async_rst_state", state, m_state);
    check("async_rst_level", level, m_level);
    repeat (2) drive(0, 0, 0, 0);
    reset_n = 1'b1;
    drive(0, 1, 0, 0);
    for (int k = 0; k < 300; k++) drive(bit'($urandom_range(0, 1)), 0, 0, int'($urandom_range(0, 3)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
